// File: rtl/count_seq_pkg.sv
// Shared state encodings and default geometry for the count sequencer and its datapath.
package count_seq_pkg;

  localparam int         DEF_W         = 4;
  localparam logic [3:0] DEF_RESET_VAL = 4'hE;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/count_core.sv
// W-bit loadable up/down counter built from per-bit D flip-flops; one-cycle update, load has priority over enable.
// No flow control: the sequencer drives load/en every cycle.
module d_ff #(
  parameter logic RST = 1'b0
) (
  input  logic clk,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) q <= RST;
    else        q <= d;
  end

endmodule

module count_core
  import count_seq_pkg::*;
#(
  parameter int         W         = DEF_W,
  parameter logic [W-1:0] RESET_VAL = W'(DEF_RESET_VAL)
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_nxt;

  // Wrap-around is the natural modulo-2^W behaviour of the W-bit add/subtract.
  always_comb begin
    q_nxt = q;
    if (load)    q_nxt = d;
    else if (en) q_nxt = up ? q + W'(1) : q - W'(1);
  end

  for (genvar i = 0; i < W; i++) begin : g_bit
    d_ff #(.RST(RESET_VAL[i])) u_ff (
      .clk   (clk),
      .rst_b (rst_b),
      .d     (q_nxt[i]),
      .q     (q[i])
    );
  end

endmodule

// File: rtl/count_sequencer.sv
// FSM that captures start/terminal/direction, loads the counter and steps it to the terminal value; done after 2+N edges.
// Starts outside IDLE are dropped (no queueing); COUNT_SEQ_AUTORELOAD_EN makes DONE reload for a periodic run.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int           W         = DEF_W,
  parameter logic [W-1:0] RESET_VAL = W'(DEF_RESET_VAL)
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] term_val,
  input  logic         dir_up,
  input  logic         abort,
  output logic [W-1:0] Q,
  output logic         busy,
  output logic         done,
  output logic         tc
);

  state_t       state, state_nxt;
  logic [W-1:0] load_r, term_r;
  logic         dir_r;
  logic         done_r;
  logic         capture;
  logic         core_load, core_en;
  logic         at_term;

  assign at_term = (Q == term_r);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state  <= S_IDLE;
      load_r <= '0;
      term_r <= '0;
      dir_r  <= 1'b1;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_r <= (state_nxt == S_DONE);
      if (capture) begin
        load_r <= load_val;
        term_r <= term_val;
        dir_r  <= dir_up;
      end
    end
  end

  // Terminal check uses the current Q, so the counter stops on term_r and never steps past it.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    core_load = 1'b0;
    core_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_nxt = S_LOAD;
          capture   = 1'b1;
        end
      end
      S_LOAD: begin
        if (abort) state_nxt = S_IDLE;
        else begin
          core_load = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (abort)        state_nxt = S_IDLE;
        else if (at_term) state_nxt = S_DONE;
        else              core_en   = 1'b1;
      end
      S_DONE: begin
`ifdef COUNT_SEQ_AUTORELOAD_EN
        state_nxt = abort ? S_IDLE : S_LOAD;
`else
        state_nxt = S_IDLE;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  count_core #(.W(W), .RESET_VAL(RESET_VAL)) u_core (
    .clk   (clk),
    .rst_b (rst_b),
    .load  (core_load),
    .en    (core_en),
    .up    (dir_r),
    .d     (load_r),
    .q     (Q)
  );

  assign busy = (state != S_IDLE);
  assign done = done_r;
  assign tc   = (state == S_RUN) && at_term;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer: reset, up/down/wrap runs, ignore/abort, mid-run reset, reload option.
module tb_count_sequencer;

  logic       clk;
  logic       rst_b;
  logic       start;
  logic [3:0] load_val;
  logic [3:0] term_val;
  logic       dir_up;
  logic       abort;
  logic [3:0] Q;
  logic       busy;
  logic       done;
  logic       tc;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  count_sequencer dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .start    (start),
    .load_val (load_val),
    .term_val (term_val),
    .dir_up   (dir_up),
    .abort    (abort),
    .Q        (Q),
    .busy     (busy),
    .done     (done),
    .tc       (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [3:0] q, input logic b,
                        input logic d, input logic t);
    chk({tag, ".Q"},    32'(Q),    32'(q));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
    chk({tag, ".tc"},   32'(tc),   32'(t));
  endtask

  task automatic go(input logic [3:0] l, input logic [3:0] t, input logic u);
    load_val = l; term_val = t; dir_up = u; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_b = 1'b1; start = 1'b0; load_val = '0; term_val = '0; dir_up = 1'b0; abort = 1'b0;

    // 1. async reset, no clock edge yet
    #2 rst_b = 1'b0;
    #1 chk_st("reset", 4'hE, 1'b0, 1'b0, 1'b0);
    tick();
    rst_b = 1'b1;
    tick();
    chk_st("reset_rel", 4'hE, 1'b0, 1'b0, 1'b0);

    // start together with abort in IDLE is refused
    start = 1'b1; abort = 1'b1; load_val = 4'h1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk_st("start_abort", 4'hE, 1'b0, 1'b0, 1'b0);

    // 2. up run 2 -> 5: done at edge k+5
    done_cnt = 0;
    go(4'h2, 4'h5, 1'b1);
    chk_st("up_load", 4'hE, 1'b1, 1'b0, 1'b0);
    load_val = 4'h9; term_val = 4'h0; dir_up = 1'b0;
    tick(); chk_st("up_q2", 4'h2, 1'b1, 1'b0, 1'b0);
    tick(); chk_st("up_q3", 4'h3, 1'b1, 1'b0, 1'b0);
    tick(); chk_st("up_q4", 4'h4, 1'b1, 1'b0, 1'b0);
    tick(); chk_st("up_q5", 4'h5, 1'b1, 1'b0, 1'b1);
    tick(); chk_st("up_done", 4'h5, 1'b1, 1'b1, 1'b0);
    tick(); chk_st("up_idle", 4'h5, 1'b0, 1'b0, 1'b0);
    tick(); chk_st("up_hold", 4'h5, 1'b0, 1'b0, 1'b0);
    chk("up_done_cnt", 32'(done_cnt), 32'd1);

    // 3. down with wrap 1 -> E; abort in DONE is harmless without reload
    done_cnt = 0;
    go(4'h1, 4'hE, 1'b0);
    chk_st("dn_load", 4'h5, 1'b1, 1'b0, 1'b0);
    tick(); chk_st("dn_q1", 4'h1, 1'b1, 1'b0, 1'b0);
    tick(); chk_st("dn_q0", 4'h0, 1'b1, 1'b0, 1'b0);
    tick(); chk_st("dn_qF", 4'hF, 1'b1, 1'b0, 1'b0);
    tick(); chk_st("dn_qE", 4'hE, 1'b1, 1'b0, 1'b1);
    tick(); chk_st("dn_done", 4'hE, 1'b1, 1'b1, 1'b0);
`ifndef COUNT_SEQ_AUTORELOAD_EN
    abort = 1'b1;
    tick(); chk_st("dn_idle", 4'hE, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;
    chk("dn_done_cnt", 32'(done_cnt), 32'd1);

    // up wrap F -> 1 and zero-length run
    go(4'hF, 4'h1, 1'b1);
    tick(); chk_st("wr_qF", 4'hF, 1'b1, 1'b0, 1'b0);
    tick(); chk_st("wr_q0", 4'h0, 1'b1, 1'b0, 1'b0);
    tick(); chk_st("wr_q1", 4'h1, 1'b1, 1'b0, 1'b1);
    tick(); chk_st("wr_done", 4'h1, 1'b1, 1'b1, 1'b0);
    tick();
    go(4'h7, 4'h7, 1'b1);
    tick(); chk_st("n0_q7", 4'h7, 1'b1, 1'b0, 1'b1);
    tick(); chk_st("n0_done", 4'h7, 1'b1, 1'b1, 1'b0);
    tick(); chk_st("n0_idle", 4'h7, 1'b0, 1'b0, 1'b0);

    // 4. restart ignored mid-run, then abort at Q=4
    done_cnt = 0;
    go(4'h0, 4'hA, 1'b1);
    tick(); chk("ab_q0", 32'(Q), 32'h0);
    tick(); tick(); tick(); chk("ab_q3", 32'(Q), 32'h3);
    start = 1'b1; load_val = 4'h9; term_val = 4'h2; dir_up = 1'b0;
    tick(); chk_st("ab_q4", 4'h4, 1'b1, 1'b0, 1'b0);
    start = 1'b0; abort = 1'b1;
    tick(); chk_st("ab_idle", 4'h4, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;
    tick(); tick(); chk_st("ab_hold", 4'h4, 1'b0, 1'b0, 1'b0);
    chk("ab_done_cnt", 32'(done_cnt), 32'd0);

    // abort during LOAD: Q must not take the load value
    go(4'h8, 4'h9, 1'b1);
    abort = 1'b1;
    tick(); chk_st("abl_idle", 4'h4, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;

    // 5. reset between edges mid-run
    go(4'h8, 4'hC, 1'b1);
    tick(); tick(); chk("mr_q9", 32'(Q), 32'h9);
    #2 rst_b = 1'b0;
    #1 chk_st("mr_reset", 4'hE, 1'b0, 1'b0, 1'b0);
    #2 rst_b = 1'b1;
    tick(); chk_st("mr_rel", 4'hE, 1'b0, 1'b0, 1'b0);
    go(4'h5, 4'h6, 1'b1);
    tick(); chk_st("mr_q5", 4'h5, 1'b1, 1'b0, 1'b0);
    tick(); chk_st("mr_q6", 4'h6, 1'b1, 1'b0, 1'b1);
    tick(); chk_st("mr_done", 4'h6, 1'b1, 1'b1, 1'b0);
    tick(); chk_st("mr_idle", 4'h6, 1'b0, 1'b0, 1'b0);
`else
    tick(); chk_st("dn_reload", 4'hE, 1'b1, 1'b0, 1'b0);
    abort = 1'b1;
    tick(); chk_st("dn_abort", 4'hE, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;

    // 6. periodic 3,4,5,(DONE) with a 5-cycle done period, abort in DONE
    done_cnt = 0;
    go(4'h3, 4'h5, 1'b1);
    for (int p = 0; p < 2; p++) begin
      tick(); chk_st("ar_q3", 4'h3, 1'b1, 1'b0, 1'b0);
      tick(); chk_st("ar_q4", 4'h4, 1'b1, 1'b0, 1'b0);
      tick(); chk_st("ar_q5", 4'h5, 1'b1, 1'b0, 1'b1);
      tick(); chk_st("ar_done", 4'h5, 1'b1, 1'b1, 1'b0);
      if (p == 0) begin
        tick(); chk_st("ar_load", 4'h5, 1'b1, 1'b0, 1'b0);
      end
    end
    abort = 1'b1;
    tick(); chk_st("ar_idle", 4'h5, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;
    tick(); chk_st("ar_hold", 4'h5, 1'b0, 1'b0, 1'b0);
    chk("ar_done_cnt", 32'(done_cnt), 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
